mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped UART transmitter with a TX FIFO.
//
// Register window (16 bytes at BASE_ADDR, offset = dmem_Addr[3:2]):
//   0x0 TXDATA  W: push WriteData[7:0] into the FIFO; R: 0
//   0x4 STATUS  R: {count[8:4], overflow[3], busy[2], empty[1], full[0]}
//               W: WriteData[3]=1 clears the sticky overflow flag
//   0x8 DIV     R/W bits[15:0]; bit period = DIV+1 cycles (0 acts as 1)
//   0xC reserved, reads 0, writes ignored
//
// Ports:
//   clk_core        core clock, rising edge
//   rst_n           synchronous active-low reset
//   dmem_Addr       data-bus byte address
//   dmem_Write      data-bus write strobe
//   dmem_WriteData  data-bus write data
//   dmem_ReadData   combinational read data, 0 when not selected
//   tx              serial output, idle high
//   tx_idle         registered: FIFO empty and FSM idle
//
// Build option: define UART_TX_PARITY_EN to append an even-parity bit
// (11-bit frame); otherwise frames are 10 bits.

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter logic [15:0] DIV_RESET  = 16'd26,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_core,
    input  logic        rst_n,
    input  logic [31:0] dmem_Addr,
    input  logic        dmem_Write,
    input  logic [31:0] dmem_WriteData,
    output logic [31:0] dmem_ReadData,
    output logic        tx,
    output logic        tx_idle
);

    localparam int         AW    = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic          sel;
    logic [1:0]    offset;
    logic          wr_sel;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          at_boundary;
    logic          bit_done;
    logic [4:0]    count;
    logic [4:0]    count_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [7:0]    head;
    logic          overflow;
    logic [15:0]   div;
    logic [15:0]   div_eff;
    logic [15:0]   bit_cnt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    state_t        state;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif
    logic          unused_bits;

    assign unused_bits = ^{dmem_Addr[1:0], dmem_WriteData[31:16]};

    assign sel      = (dmem_Addr[31:4] == BASE_ADDR[31:4]);
    assign offset   = dmem_Addr[3:2];
    assign wr_sel   = dmem_Write && sel;
    assign push_req = wr_sel && (offset == 2'd0);

    assign full     = (count == DEPTH);
    assign empty    = (count == 5'd0);
    assign busy     = (state != IDLE);
    assign bit_done = (bit_cnt == 16'd0);
    assign head     = mem[rd_ptr];
    assign div_eff  = (div == 16'd0) ? 16'd1 : div;

    // A frame may begin either from IDLE or straight out of the last STOP
    // cycle, which is what keeps back-to-back frames gapless.
    assign at_boundary = (state == IDLE) || ((state == STOP) && bit_done);
    assign pop         = at_boundary && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push        = push_req && (!full || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 5'd1;
            2'b01:   count_next = count - 5'd1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        dmem_ReadData = 32'd0;
        if (sel) begin
            case (offset)
                2'd1:    dmem_ReadData = {23'd0, count, overflow, busy, empty, full};
                2'd2:    dmem_ReadData = {16'd0, div};
                default: dmem_ReadData = 32'd0;
            endcase
        end
    end

    // FIFO pointers, occupancy and the register file.
    always_ff @(posedge clk_core) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
            div      <= DIV_RESET;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (wr_sel && (offset == 2'd1) && dmem_WriteData[3])
                overflow <= 1'b0;
            if (wr_sel && (offset == 2'd2))
                div <= dmem_WriteData[15:0];
        end
    end

    always_ff @(posedge clk_core) begin
        if (push) mem[wr_ptr] <= dmem_WriteData[7:0];
    end

    // Transmit FSM. tx and tx_idle are registered; tx_idle looks ahead at
    // the post-edge FIFO count so it is exact in the cycle it is seen.
    always_ff @(posedge clk_core) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
            tx_idle <= 1'b1;
        end else begin
            tx_idle <= at_boundary && empty && (count_next == 5'd0);
            if (pop) begin
                state   <= START;
                shreg   <= head;
                tx      <= 1'b0;
                bit_cnt <= div_eff;
`ifdef UART_TX_PARITY_EN
                parity  <= ^head;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx <= 1'b1;
                    end
                    START: begin
                        if (bit_done) begin
                            state   <= DATA;
                            tx      <= shreg[0];
                            bit_idx <= 3'd0;
                            bit_cnt <= div_eff;
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    DATA: begin
                        if (bit_done) begin
                            bit_cnt <= div_eff;
                            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                tx    <= parity;
`else
                                state <= STOP;
                                tx    <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shreg   <= shreg >> 1;
                                tx      <= shreg[1];
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_done) begin
                            state   <= STOP;
                            tx      <= 1'b1;
                            bit_cnt <= div_eff;
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
`endif
                    STOP: begin
                        // A non-empty FIFO at the end of STOP is handled by pop.
                        if (bit_done) begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
